// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // 50 MHz core clock / 9600 baud
   localparam int DEFAULT_BAUD_DIV = 5208;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side bundle of the UART transmitter: push strobe/word in, queue and frame status out.
// Wires only; push is accepted while full is low, otherwise the word is dropped and overflow pulses.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 trmt;
   logic [DATA_BITS-1:0] tx_data;
   logic                 full;
   logic                 overflow;
   logic                 busy;
   logic                 tx_done;

   modport master (
      output trmt, tx_data,
      input  full, overflow, busy, tx_done
   );

   modport slave (
      input  trmt, tx_data,
      output full, overflow, busy, tx_done
   );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head word with zero latency.
// Push while full is ignored, pop while empty is ignored; a pop never frees space for a same-cycle push.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so pointer wrap is plain binary overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// Queued UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits, frames back-to-back.
// Start bit leaves one cycle after a push into an idle unit; host is held off by full, excess pushes drop with overflow.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_cfg_if.slave  host,
   output logic          TX
);
   localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   tx_state_e            state, state_n;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par_bit, par_n;
   logic                 tx_n;
   logic                 done_n;
   logic                 done_q;
   logic                 ovf_q;
   logic                 bit_end;
   logic                 pop;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (host.trmt),
      .pop   (pop),
      .din   (host.tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bit_end       = (baud_cnt == BAUD_LAST);
   assign host.full     = fifo_full;
   assign host.overflow = ovf_q;
   assign host.tx_done  = done_q;
   assign host.busy     = (state != ST_IDLE) || !fifo_empty;

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      done_n  = 1'b0;
      shreg_n = shreg;
      par_n   = par_bit;
      tx_n    = 1'b1;

      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) state_n = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && (bit_cnt == DATA_LAST))
               state_n = (PARITY != int'(PAR_NONE)) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (bit_end) state_n = ST_STOP;
         end
         ST_STOP: begin
            if (bit_end && (bit_cnt == STOP_LAST)) begin
               done_n = 1'b1;
               // chain straight into the next start bit when more words wait
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (pop) begin
         shreg_n = fifo_dout;
         par_n   = (^fifo_dout) ^ (PARITY == int'(PAR_ODD));
      end else if ((state == ST_DATA) && bit_end) begin
         shreg_n = shreg >> 1;
      end

      // line level is registered, so it is derived from the state being entered
      case (state_n)
         ST_START:  tx_n = 1'b0;
         ST_DATA:   tx_n = shreg_n[0];
         ST_PARITY: tx_n = par_n;
         default:   tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         TX       <= 1'b1;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= ((state == ST_IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;
         if (state_n != state)
            bit_cnt <= '0;
         else if (bit_end)
            bit_cnt <= bit_cnt + 1'b1;
         shreg    <= shreg_n;
         par_bit  <= par_n;
         TX       <= tx_n;
         done_q   <= done_n;
         ovf_q    <= host.trmt & fifo_full;
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg over four configurations (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=4.
// A line monitor decodes frames and checks them against a scoreboard of accepted words.
module tb_uart_tx_cfg;
   localparam int BAUD = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int   vectors = 0;
   int   miscompares = 0;
   int   sel;
   logic trmt;
   logic [8:0] tx_data;
   logic       mon_en;
   int   m_bits, m_par, m_stop;
   logic [8:0] mask;
   logic [8:0] sb[$];
   int   frames = 0;
   int   b2b = 0;
   int   done_cnt = 0;

   logic tx0, tx1, tx2, tx3;
   logic tx_mon, done_mon, full_mon, ovf_mon, busy_mon;

   uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

   assign if0.trmt = trmt && (sel == 0);
   assign if1.trmt = trmt && (sel == 1);
   assign if2.trmt = trmt && (sel == 2);
   assign if3.trmt = trmt && (sel == 3);
   assign if0.tx_data = tx_data[7:0];
   assign if1.tx_data = tx_data[7:0];
   assign if2.tx_data = tx_data[7:0];
   assign if3.tx_data = tx_data[6:0];

   uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut (.clk(clk), .rst_n(rst_n), .host(if0), .TX(tx0));
   uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_even (.clk(clk), .rst_n(rst_n), .host(if1), .TX(tx1));
   uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_odd (.clk(clk), .rst_n(rst_n), .host(if2), .TX(tx2));
   uart_tx_cfg #(.DATA_BITS(7), .BAUD_DIV(BAUD), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut_7n2 (.clk(clk), .rst_n(rst_n), .host(if3), .TX(tx3));

   always_comb begin
      case (sel)
         1:       begin tx_mon = tx1; done_mon = if1.tx_done; full_mon = if1.full; ovf_mon = if1.overflow; busy_mon = if1.busy; end
         2:       begin tx_mon = tx2; done_mon = if2.tx_done; full_mon = if2.full; ovf_mon = if2.overflow; busy_mon = if2.busy; end
         3:       begin tx_mon = tx3; done_mon = if3.tx_done; full_mon = if3.full; ovf_mon = if3.overflow; busy_mon = if3.busy; end
         default: begin tx_mon = tx0; done_mon = if0.tx_done; full_mon = if0.full; ovf_mon = if0.overflow; busy_mon = if0.busy; end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decode one frame whose start bit is visible at the current negedge.
   task automatic mon_frame();
      logic [8:0] w;
      logic       fb[13];
      logic       bad_obs;
      logic       p;
      int         nb;
      check("frame_expected", (sb.size() != 0), 1);
      if (sb.size() == 0) begin
         wait (tx_mon === 1'b1 || !mon_en);
         return;
      end
      w  = sb.pop_front();
      p  = (^(w & mask)) ^ (m_par == 2);
      nb = 0;
      fb[nb] = 1'b0; nb++;
      for (int i = 0; i < m_bits; i++) begin fb[nb] = w[i]; nb++; end
      if (m_par != 0) begin fb[nb] = p; nb++; end
      for (int i = 0; i < m_stop; i++) begin fb[nb] = 1'b1; nb++; end
      for (int b = 0; b < nb; b++) begin
         bad_obs = fb[b];
         for (int c = 0; c < BAUD; c++) begin
            if (b != 0 || c != 0) begin
               @(negedge clk);
               if (!mon_en) return;
            end
            if (tx_mon !== fb[b]) bad_obs = tx_mon;
         end
         check($sformatf("tx_bit%0d_word%0h", b, w), bad_obs, fb[b]);
      end
      @(negedge clk);
      if (!mon_en) return;
      check($sformatf("tx_done_word%0h", w), done_mon, 1);
      frames++;
      if (tx_mon === 1'b0) b2b++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (mon_en && tx_mon === 1'b0) mon_frame();
      end
   end

   always @(negedge clk) if (done_mon === 1'b1) done_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic select(input int s, input int bits, input int par, input int stop);
      sel    = s;
      m_bits = bits;
      m_par  = par;
      m_stop = stop;
      mask   = 9'((1 << bits) - 1);
   endtask

   task automatic push(input logic [8:0] w, input bit accept);
      if (accept) sb.push_back(w & mask);
      trmt    = 1'b1;
      tx_data = w;
      @(negedge clk);
      trmt    = 1'b0;
   endtask

   // Called at the negedge after a push into an idle unit.
   task automatic measure_frame(input string tag, input int exp_len);
      int n;
      @(negedge clk);
      check({tag, "_start_bit"}, tx_mon, 0);
      n = 0;
      while (done_mon !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_frame_len"}, n, exp_len);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy_mon !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_in_time"}, (n < 2000), 1);
      repeat (3) @(negedge clk);
      check({tag, "_sb_drained"}, sb.size(), 0);
      check({tag, "_busy_low"}, busy_mon, 0);
   endtask

   initial begin
      int d0, b0;
      trmt    = 1'b0;
      tx_data = '0;
      mon_en  = 1'b0;
      rst_n   = 1'b0;
      select(0, 8, 0, 1);
      repeat (3) @(negedge clk);
      check("rst_tx", tx_mon, 1);
      check("rst_tx_done", done_mon, 0);
      check("rst_overflow", ovf_mon, 0);
      check("rst_busy", busy_mon, 0);
      check("rst_full", full_mon, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // 8N1 latency and frame length
      push(9'h0A5, 1'b1);
      check("lat_tx_high_after_push", tx_mon, 1);
      check("lat_busy_after_push", busy_mon, 1);
      measure_frame("8n1_a5", 40);
      wait_idle("8n1_a5");

      // queue fill, overflow and back-to-back frames
      d0 = done_cnt;
      b0 = b2b;
      push(9'h011, 1'b1);
      push(9'h022, 1'b1);
      push(9'h033, 1'b1);
      push(9'h044, 1'b1);
      push(9'h055, 1'b1);
      check("fifo_full_after_5", full_mon, 1);
      check("fifo_no_ovf_on_5th", ovf_mon, 0);
      push(9'h066, 1'b0);
      check("fifo_ovf_pulse", ovf_mon, 1);
      @(negedge clk);
      check("fifo_ovf_one_cycle", ovf_mon, 0);
      wait_idle("fifo5");
      check("fifo_done_count", done_cnt - d0, 5);
      check("fifo_back_to_back", b2b - b0, 4);

      // even parity
      select(1, 8, 1, 1);
      push(9'h0A5, 1'b1);
      measure_frame("8e1_a5", 44);
      push(9'h001, 1'b1);
      measure_frame("8e1_01", 44);
      wait_idle("8e1");

      // odd parity
      select(2, 8, 2, 1);
      push(9'h0A5, 1'b1);
      push(9'h001, 1'b1);
      wait_idle("8o1");

      // 7 data bits, 2 stop bits
      select(3, 7, 0, 2);
      push(9'h07F, 1'b1);
      measure_frame("7n2_7f", 40);
      wait_idle("7n2");

      // reset in the middle of data bit 3 with a full queue
      select(0, 8, 0, 1);
      push(9'h05A, 1'b1);
      push(9'h011, 1'b1);
      push(9'h022, 1'b1);
      push(9'h033, 1'b1);
      push(9'h044, 1'b1);
      check("pre_rst_full", full_mon, 1);
      repeat (13) @(negedge clk);
      mon_en = 1'b0;
      @(negedge clk);
      check("pre_rst_data_bit3", tx_mon, 1);
      check("pre_rst_busy", busy_mon, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", tx_mon, 1);
      check("mid_rst_busy", busy_mon, 0);
      check("mid_rst_full", full_mon, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      push(9'h0C3, 1'b1);
      measure_frame("post_rst_c3", 40);
      wait_idle("post_rst");

      // push on the same edge the transmitter pops from a 3-deep queue
      push(9'h010, 1'b1);
      push(9'h020, 1'b1);
      push(9'h030, 1'b1);
      push(9'h040, 1'b1);
      repeat (37) @(negedge clk);
      check("sim_pre_full", full_mon, 0);
      push(9'h050, 1'b1);
      check("sim_pushpop_not_full", full_mon, 0);
      check("sim_pushpop_next_start", tx_mon, 0);
      push(9'h060, 1'b1);
      check("sim_after_extra_full", full_mon, 1);
      check("sim_after_extra_no_ovf", ovf_mon, 0);
      wait_idle("sim");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that serialises DATA_BITS-wide words with a configurable baud divisor, optional parity and 1 or 2 stop bits. A small FIFO lets the host queue bytes, and frames go out back-to-back with no idle gap. It is the drop-in successor transmitter for the telemetry/command serial links, and sits between the host packet logic and the TX pad.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
BAUD_DIV, 5208, clk cycles per bit period (>=2); counter width $clog2(BAUD_DIV)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, entries in the transmit queue (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trmt  in  1  push strobe; tx_data is written when trmt=1 and full=0
tx_data  in  DATA_BITS  word to queue
full  out  1  FIFO full; combinational from the occupancy count
overflow  out  1  one-cycle pulse when trmt=1 while full=1 (word dropped)
busy  out  1  high while a frame is on the line or the FIFO is non-empty
TX  out  1  serial line, registered output, idles high
tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset state: TX=1, tx_done=0, overflow=0, busy=0, full=0; FIFO pointers and count cleared; FSM in IDLE.
- Reset mid-frame: the line returns high immediately and queued words are discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. That edge pops the head word, loads the shift register and clears the baud counter; TX=0 from that edge.
  - Each state holds TX for exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1, and bit_end is asserted at BAUD_DIV-1.
  - START -> DATA on bit_end.
  - DATA shifts out LSB first; the bit counter counts 0..DATA_BITS-1. On the last bit_end it goes to PARITY if PARITY!=0, else STOP.
  - PARITY: TX = XOR of the data bits (even), or its inverse (odd). Parity is computed at load from the popped word.
  - STOP: TX=1 for STOP_BITS*BAUD_DIV cycles. On the final bit_end, tx_done pulses for one cycle.
    - If the FIFO is non-empty, the same edge pops the next word and enters START (no idle gap).
    - Otherwise the FSM enters IDLE.
- Latency: with the FSM in IDLE and the FIFO empty, trmt sampled at edge E0 makes TX=0 after edge E1. The start bit begins exactly 1 cycle after the push.
- Frame length: BAUD_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles from the start-bit edge to the tx_done edge.
- FIFO:
  - full = (count==FIFO_DEPTH). A push while full is dropped and pulses overflow; a pop in the same cycle does not rescue it.
  - Push and pop in the same cycle when not full: count is unchanged and both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- tx_data is captured at push; later changes to tx_data do not affect queued words.
- busy = (state!=IDLE) | (count!=0).

Decomposition:
- Package uart_pkg holds:
  - the parity enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - the tx state typedef
  - the DEFAULT_BAUD_DIV constant (5208 = 50 MHz / 9600)
- One sub-module: uart_fifo. It is a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty, and first-word-fall-through dout.

Test Plan:
- 8N1, BAUD_DIV=4, push 0xA5 from idle -> TX=0 one cycle after the push. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then TX=1. tx_done pulses 40 cycles after the start-bit edge.
- PARITY=1 (even) then PARITY=2 (odd), push 0xA5 -> parity bit 0 then 1. Push 0x01 -> parity bit 1 then 0. Frame is 44 cycles.
- STOP_BITS=2, DATA_BITS=7, push 0x7F -> seven 1s, stop high for 8 cycles, tx_done at cycle 40.
- FIFO_DEPTH=4, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
  - the first pops immediately, so 0x55 is accepted with no overflow
  - a 6th push (0x66) while full=1 produces overflow=1 for one cycle and the word is dropped
  - frames go out back-to-back with no idle cycle between stop and start
  - tx_done pulses 5 times, then busy=0
- Assert rst_n=0 mid DATA bit 3 of 0x5A -> TX=1, busy=0 and full=0 immediately. After release, a new push of 0xC3 transmits correctly from a clean start.
- Simultaneous push and pop: with the FIFO holding 3 entries, push on the exact edge the FSM pops -> count stays 3 and all words are sent in order.
